rename_stage: RTL

RENAME_STAGE -- requirements
Module: rename_stage

---
 rtl/rename_stage_pkg.sv | 55 +++++
 rtl/rename_free_list.sv | 69 ++++++
 rtl/rename_stage.sv | 118 +++++++++++
 3 files changed

// File: rtl/rename_stage_pkg.sv
// Shared types and configuration for the register rename stage.
package rename_stage_pkg;

  localparam int unsigned CFG_FETCH_WIDTH  = 2;
  localparam int unsigned CFG_COMMIT_WIDTH = 2;
  localparam int unsigned CFG_PHYS_REGS    = 64;
  localparam int unsigned ARCH_REGS        = 32;
  localparam int unsigned PREG_W           = $clog2(CFG_PHYS_REGS);
  localparam int unsigned AREG_W           = 5;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [AREG_W-1:0] areg_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [6:0]  opcode;
    areg_t       rs1;
    areg_t       rs2;
    areg_t       rd;
    logic        rd_we;
  } decoded_instr_t;

  typedef struct packed {
    logic           valid;
    preg_t          prs1;
    preg_t          prs2;
    preg_t          prd;
    preg_t          old_prd;
    logic           rd_we;
    decoded_instr_t dec;
  } renamed_instr_t;

  typedef struct packed {
    logic  valid;
    areg_t rd;
    logic  rd_we;
    preg_t prd;
    preg_t old_prd;
  } commit_info_t;

  // Circular pointer advance; n never exceeds a group width, so one wrap suffices.
  function automatic preg_t ptr_add(preg_t p, int unsigned n, int unsigned m);
    int unsigned s;
    s = 32'(p) + n;
    if (s >= m) s = s - m;
    return preg_t'(s);
  endfunction

  function automatic int unsigned ptr_dist(preg_t t, preg_t h, int unsigned m);
    if (t >= h) return 32'(t) - 32'(h);
    return 32'(t) + m - 32'(h);
  endfunction

endpackage

// File: rtl/rename_free_list.sv
// Physical register free list: circular FIFO with speculative and committed heads.
module rename_free_list
  import rename_stage_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH  = CFG_FETCH_WIDTH,
  parameter int unsigned COMMIT_WIDTH = CFG_COMMIT_WIDTH,
  parameter int unsigned PHYS_REGS    = CFG_PHYS_REGS
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 alloc,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0]     alloc_cnt,
  input  logic [COMMIT_WIDTH-1:0]              push_valid,
  input  preg_t [COMMIT_WIDTH-1:0]             push_preg,
  input  logic                                 flush,
  output preg_t [FETCH_WIDTH-1:0]              pop_preg,
  output logic [PREG_W:0]                      free_count
);

  localparam int unsigned CNT_W = PREG_W + 1;

  preg_t       fifo [PHYS_REGS];
  preg_t       spec_head;
  preg_t       commit_head;
  preg_t       tail;
  preg_t       push_ptr [COMMIT_WIDTH];
  preg_t       tail_nxt;
  preg_t       commit_head_nxt;
  int unsigned n_push;
  logic [CNT_W-1:0] pops;

  always_comb begin
    for (int unsigned k = 0; k < FETCH_WIDTH; k++)
      pop_preg[k] = fifo[ptr_add(spec_head, k, PHYS_REGS)];
    n_push = 0;
    for (int unsigned c = 0; c < COMMIT_WIDTH; c++) begin
      push_ptr[c] = ptr_add(tail, n_push, PHYS_REGS);
      if (push_valid[c]) n_push = n_push + 1;
    end
    tail_nxt        = ptr_add(tail, n_push, PHYS_REGS);
    commit_head_nxt = ptr_add(commit_head, n_push, PHYS_REGS);
    pops            = alloc ? CNT_W'(alloc_cnt) : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < PHYS_REGS; i++)
        fifo[i] <= (i < PHYS_REGS - ARCH_REGS) ? preg_t'(i + ARCH_REGS) : '0;
      spec_head   <= '0;
      commit_head <= '0;
      tail        <= preg_t'(PHYS_REGS - ARCH_REGS);
      free_count  <= CNT_W'(PHYS_REGS - ARCH_REGS);
    end else begin
      for (int unsigned c = 0; c < COMMIT_WIDTH; c++)
        if (push_valid[c]) fifo[push_ptr[c]] <= push_preg[c];
      tail        <= tail_nxt;
      commit_head <= commit_head_nxt;
      // Flush rewinds to the post-commit head; count is rebuilt from the pointers.
      if (flush) begin
        spec_head  <= commit_head_nxt;
        free_count <= CNT_W'(ptr_dist(tail_nxt, commit_head_nxt, PHYS_REGS));
      end else begin
        spec_head  <= ptr_add(spec_head, 32'(pops), PHYS_REGS);
        free_count <= free_count - pops + CNT_W'(n_push);
      end
    end
  end

endmodule

// File: rtl/rename_stage.sv
// Register rename stage: RAT lookup with in-group bypass, free-list allocation, commit/flush.
module rename_stage
  import rename_stage_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH  = CFG_FETCH_WIDTH,
  parameter int unsigned COMMIT_WIDTH = CFG_COMMIT_WIDTH,
  parameter int unsigned PHYS_REGS    = CFG_PHYS_REGS
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  decoded_instr_t [FETCH_WIDTH-1:0]     i_instrs,
  output logic                                 o_dequeue,
  input  logic                                 i_stall,
  input  logic                                 i_flush,
  input  commit_info_t [COMMIT_WIDTH-1:0]      i_commit,
  output renamed_instr_t [FETCH_WIDTH-1:0]     o_instrs
);

  localparam int unsigned ACNT_W = $clog2(FETCH_WIDTH + 1);

  preg_t spec_rat     [ARCH_REGS];
  preg_t comm_rat     [ARCH_REGS];
  preg_t comm_rat_nxt [ARCH_REGS];

  logic [FETCH_WIDTH-1:0]          qwe;
  logic [ACNT_W-1:0]               n_alloc;
  int unsigned                     a;
  logic                            any_valid;
  logic                            accept;
  preg_t [FETCH_WIDTH-1:0]         pop_preg;
  logic [PREG_W:0]                 free_count;
  renamed_instr_t [FETCH_WIDTH-1:0] renamed;
  logic [COMMIT_WIDTH-1:0]         cqwe;
  preg_t [COMMIT_WIDTH-1:0]        push_preg;

  always_comb begin
    any_valid = 1'b0;
    renamed   = '0;
    a         = 0;
    for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
      qwe[k] = i_instrs[k].valid && i_instrs[k].rd_we && (i_instrs[k].rd != '0);
      any_valid = any_valid | i_instrs[k].valid;
    end
    for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
      renamed[k].dec     = i_instrs[k];
      renamed[k].valid   = i_instrs[k].valid;
      renamed[k].rd_we   = qwe[k];
      renamed[k].prs1    = spec_rat[i_instrs[k].rs1];
      renamed[k].prs2    = spec_rat[i_instrs[k].rs2];
      renamed[k].old_prd = spec_rat[i_instrs[k].rd];
      // Ascending scan leaves the youngest older writer in place.
      for (int unsigned j = 0; j < FETCH_WIDTH; j++) begin
        if (j < k && qwe[j]) begin
          if (i_instrs[j].rd == i_instrs[k].rs1) renamed[k].prs1    = renamed[j].prd;
          if (i_instrs[j].rd == i_instrs[k].rs2) renamed[k].prs2    = renamed[j].prd;
          if (i_instrs[j].rd == i_instrs[k].rd)  renamed[k].old_prd = renamed[j].prd;
        end
      end
      if (qwe[k]) begin
        renamed[k].prd = pop_preg[a];
        a = a + 1;
      end
    end
    n_alloc   = ACNT_W'(a);
    accept    = i_rst_n && any_valid && !i_stall && !i_flush &&
                (free_count >= (PREG_W + 1)'(n_alloc));
    o_dequeue = accept;
  end

  always_comb begin
    comm_rat_nxt = comm_rat;
    for (int unsigned c = 0; c < COMMIT_WIDTH; c++) begin
      cqwe[c]      = i_commit[c].valid && i_commit[c].rd_we && (i_commit[c].rd != '0);
      push_preg[c] = i_commit[c].old_prd;
      if (cqwe[c]) comm_rat_nxt[i_commit[c].rd] = i_commit[c].prd;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) begin
        spec_rat[i] <= preg_t'(i);
        comm_rat[i] <= preg_t'(i);
      end
      o_instrs <= '0;
    end else begin
      comm_rat <= comm_rat_nxt;
      if (i_flush) begin
        spec_rat <= comm_rat_nxt;
      end else if (accept) begin
        for (int unsigned k = 0; k < FETCH_WIDTH; k++)
          if (qwe[k]) spec_rat[i_instrs[k].rd] <= renamed[k].prd;
      end
      if (i_flush || (!i_stall && !accept)) begin
        for (int unsigned k = 0; k < FETCH_WIDTH; k++) o_instrs[k].valid <= 1'b0;
      end else if (accept) begin
        o_instrs <= renamed;
      end
    end
  end

  rename_free_list #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .COMMIT_WIDTH(COMMIT_WIDTH),
    .PHYS_REGS   (PHYS_REGS)
  ) u_free_list (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .alloc     (accept),
    .alloc_cnt (n_alloc),
    .push_valid(cqwe),
    .push_preg (push_preg),
    .flush     (i_flush),
    .pop_preg  (pop_preg),
    .free_count(free_count)
  );

endmodule
